axi4_lite_master: RTL and testbench

Bus master bridge between the RV32IM core's data-memory port and the AXI4-Lite interconnect; it is the stage that drives the `axi4_lite_slave` peripheral wrappers. It converts a single CPU load or store request into one AXI4-Lite read or write transaction and stalls the core until the response returns. It is single-outstanding, with no pipelining of requests, and it reports the transaction response to the core.

---
 rtl/axi4_lite_master.sv | 252 +++++++++++++++++++++++++
 tb/tb_axi4_lite_master.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master.sv
// -----------------------------------------------------------------------------
// axi4_lite_master
// Bridges the RV32IM data-memory port onto AXI4-Lite. One CPU load or store
// becomes one AXI4-Lite read or write transaction. Only one transaction is in
// flight at a time, and the core is stalled until its response returns.
//
// Ports
//   clk, rst         : system clock; synchronous active-high reset
//   mem_read/write   : CPU request levels, held while stall=1
//   byte_en/addr/    : store strobes, request address, store data
//   write_data
//   read_data        : load data, valid in the done cycle, held until next load
//   done             : one-cycle completion pulse
//   resp_err         : response was not OKAY, valid with done
//   stall            : combinational; core must hold its request
//   M_AXI_*          : AXI4-Lite master channels AW, W, B, AR, R
// -----------------------------------------------------------------------------
module axi4_lite_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [3:0]            byte_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  done,
    output logic                  resp_err,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [3:0]            M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    localparam int unsigned STRB_WIDTH = 4;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_RESP = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    // Current-state registers
    logic [2:0]            r_state;
    logic                  r_awch_done;
    logic                  r_wch_done;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic                  r_awvalid;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic                  r_wvalid;
    logic                  r_bready;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_arvalid;
    logic                  r_rready;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_done;
    logic                  r_resp_err;

    // Next-state values
    logic [2:0]            w_state_nxt;
    logic                  w_awch_done_nxt;
    logic                  w_wch_done_nxt;
    logic [ADDR_WIDTH-1:0] w_awaddr_nxt;
    logic                  w_awvalid_nxt;
    logic [DATA_WIDTH-1:0] w_wdata_nxt;
    logic [STRB_WIDTH-1:0] w_wstrb_nxt;
    logic                  w_wvalid_nxt;
    logic                  w_bready_nxt;
    logic [ADDR_WIDTH-1:0] w_araddr_nxt;
    logic                  w_arvalid_nxt;
    logic                  w_rready_nxt;
    logic [DATA_WIDTH-1:0] w_read_data_nxt;
    logic                  w_done_nxt;
    logic                  w_resp_err_nxt;

    // Handshakes seen this cycle on the write-address and write-data channels
    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_ok;
    logic w_w_ok;

    assign w_aw_hs = r_awvalid & M_AXI_AWREADY;
    assign w_w_hs  = r_wvalid  & M_AXI_WREADY;
    // A channel counts as complete if it finished earlier or finishes now
    assign w_aw_ok = r_awch_done | w_aw_hs;
    assign w_w_ok  = r_wch_done  | w_w_hs;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_awch_done <= 1'b0;
            r_wch_done  <= 1'b0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_read_data <= '0;
            r_done      <= 1'b0;
            r_resp_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_awch_done <= w_awch_done_nxt;
            r_wch_done  <= w_wch_done_nxt;
            r_awaddr    <= w_awaddr_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_araddr    <= w_araddr_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_read_data <= w_read_data_nxt;
            r_done      <= w_done_nxt;
            r_resp_err  <= w_resp_err_nxt;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_awch_done_nxt = r_awch_done;
        w_wch_done_nxt  = r_wch_done;
        w_awaddr_nxt    = r_awaddr;
        w_awvalid_nxt   = r_awvalid;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_araddr_nxt    = r_araddr;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_read_data_nxt = r_read_data;
        w_done_nxt      = 1'b0;
        w_resp_err_nxt  = r_resp_err;

        case (r_state)
            S_IDLE: begin
                // A simultaneous read is dropped; the write takes priority
                if (mem_write) begin
                    w_awaddr_nxt    = addr;
                    w_wdata_nxt     = write_data;
                    w_wstrb_nxt     = byte_en;
                    w_awvalid_nxt   = 1'b1;
                    w_wvalid_nxt    = 1'b1;
                    w_awch_done_nxt = 1'b0;
                    w_wch_done_nxt  = 1'b0;
                    w_state_nxt     = S_WR_REQ;
                end else if (mem_read) begin
                    w_araddr_nxt  = addr;
                    w_arvalid_nxt = 1'b1;
                    w_state_nxt   = S_RD_REQ;
                end
            end

            S_WR_REQ: begin
                if (w_aw_hs) begin
                    w_awvalid_nxt   = 1'b0;
                    w_awch_done_nxt = 1'b1;
                end
                if (w_w_hs) begin
                    w_wvalid_nxt   = 1'b0;
                    w_wch_done_nxt = 1'b1;
                end
                if (w_aw_ok && w_w_ok) begin
                    w_awch_done_nxt = 1'b0;
                    w_wch_done_nxt  = 1'b0;
                    w_bready_nxt    = 1'b1;
                    w_state_nxt     = S_WR_RESP;
                end
            end

            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    w_resp_err_nxt = (M_AXI_BRESP != 2'b00);
                    w_bready_nxt   = 1'b0;
                    w_done_nxt     = 1'b1;
                    w_state_nxt    = S_DONE;
                end
            end

            S_RD_REQ: begin
                if (M_AXI_ARREADY) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = S_RD_RESP;
                end
            end

            S_RD_RESP: begin
                if (M_AXI_RVALID) begin
                    w_read_data_nxt = M_AXI_RDATA;
                    w_resp_err_nxt  = (M_AXI_RRESP != 2'b00);
                    w_rready_nxt    = 1'b0;
                    w_done_nxt      = 1'b1;
                    w_state_nxt     = S_DONE;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Stall from the moment a request is seen in IDLE until the DONE cycle
    assign stall = ((r_state == S_IDLE) && (mem_read || mem_write)) ||
                   ((r_state != S_IDLE) && (r_state != S_DONE));

    assign read_data     = r_read_data;
    assign done          = r_done;
    assign resp_err      = r_resp_err;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi4_lite_master.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_master
// Scoreboard bench: the driver pushes the expected outcome of each request into
// a queue; a monitor watches the AXI channels and pops/compares on every done.
// A small AXI4-Lite memory slave with configurable ready delays and responses
// answers the DUT.
// -----------------------------------------------------------------------------
module tb_axi4_lite_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read, mem_write;
    logic [3:0]    byte_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;
    logic          done, resp_err, stall;
    logic [AW-1:0] M_AXI_AWADDR;
    logic          M_AXI_AWVALID, M_AXI_AWREADY;
    logic [DW-1:0] M_AXI_WDATA;
    logic [3:0]    M_AXI_WSTRB;
    logic          M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]    M_AXI_BRESP;
    logic          M_AXI_BVALID, M_AXI_BREADY;
    logic [AW-1:0] M_AXI_ARADDR;
    logic          M_AXI_ARVALID, M_AXI_ARREADY;
    logic [DW-1:0] M_AXI_RDATA;
    logic [1:0]    M_AXI_RRESP;
    logic          M_AXI_RVALID, M_AXI_RREADY;

    always #5 clk = ~clk;

    axi4_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .byte_en(byte_en),
        .addr(addr), .write_data(write_data), .read_data(read_data),
        .done(done), .resp_err(resp_err), .stall(stall),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    // ---------------- cycle counter ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // ---------------- AXI4-Lite memory slave ----------------
    logic [31:0] mem [0:15];
    int          aw_delay = 0;
    int          w_delay  = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;
    logic        hold_r    = 1'b0;
    int          aw_wait, w_wait;
    logic        got_aw, got_w;
    logic [31:0] lat_awaddr, lat_wdata;
    logic [3:0]  lat_wstrb;
    logic        s_bvalid, s_rvalid;
    logic [31:0] s_rdata;
    logic        aw_hs, w_hs;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;

    assign M_AXI_AWREADY = (aw_wait >= aw_delay);
    assign M_AXI_WREADY  = (w_wait >= w_delay);
    assign M_AXI_ARREADY = 1'b1;
    assign M_AXI_BVALID  = s_bvalid;
    assign M_AXI_BRESP   = bresp_cfg;
    assign M_AXI_RVALID  = s_rvalid & ~hold_r;
    assign M_AXI_RDATA   = s_rdata;
    assign M_AXI_RRESP   = rresp_cfg;
    assign aw_hs   = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs    = M_AXI_WVALID & M_AXI_WREADY;
    assign wr_addr = aw_hs ? M_AXI_AWADDR : lat_awaddr;
    assign wr_data = w_hs ? M_AXI_WDATA : lat_wdata;
    assign wr_strb = w_hs ? M_AXI_WSTRB : lat_wstrb;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[9]     <= 32'h1234_5678;
            aw_wait    <= 0;
            w_wait     <= 0;
            got_aw     <= 1'b0;
            got_w      <= 1'b0;
            lat_awaddr <= 32'h0;
            lat_wdata  <= 32'h0;
            lat_wstrb  <= 4'h0;
            s_bvalid   <= 1'b0;
            s_rvalid   <= 1'b0;
            s_rdata    <= 32'h0;
        end else begin
            if (aw_hs) begin
                got_aw <= 1'b1; lat_awaddr <= M_AXI_AWADDR; aw_wait <= 0;
            end else if (M_AXI_AWVALID) aw_wait <= aw_wait + 1;
            if (w_hs) begin
                got_w <= 1'b1; lat_wdata <= M_AXI_WDATA; lat_wstrb <= M_AXI_WSTRB; w_wait <= 0;
            end else if (M_AXI_WVALID) w_wait <= w_wait + 1;
            if (s_bvalid && M_AXI_BREADY) s_bvalid <= 1'b0;
            if ((got_aw || aw_hs) && (got_w || w_hs) && !s_bvalid) begin
                for (int b = 0; b < 4; b++)
                    if (wr_strb[b]) mem[wr_addr[5:2]][8*b +: 8] <= wr_data[8*b +: 8];
                s_bvalid <= 1'b1;
                got_aw   <= 1'b0;
                got_w    <= 1'b0;
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                s_rvalid <= 1'b1;
                s_rdata  <= mem[M_AXI_ARADDR[5:2]];
            end else if (s_rvalid && !hold_r && M_AXI_RREADY) s_rvalid <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          stall_cyc;
        int          a_cyc;
        int          w_cyc;
        int          issue;
    } exp_t;

    exp_t sbq[$];

    // monitor trackers, cleared at each done and at reset
    int          t_stall, t_aw, t_w, t_ar;
    logic [31:0] t_addr, t_data, t_wprev;
    logic [3:0]  t_strb;
    logic        t_wprev_v, t_wchg;

    task automatic clear_trackers();
        t_stall = 0; t_aw = 0; t_w = 0; t_ar = 0;
        t_addr = 32'hx; t_data = 32'hx; t_strb = 4'hx;
        t_wprev = 32'h0; t_wprev_v = 1'b0; t_wchg = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            clear_trackers();
        end else begin
            if (stall) t_stall++;
            if (M_AXI_AWVALID) t_aw++;
            if (M_AXI_ARVALID) t_ar++;
            if (M_AXI_WVALID) begin
                t_w++;
                if (t_wprev_v && (M_AXI_WDATA !== t_wprev)) t_wchg = 1'b1;
            end
            t_wprev   = M_AXI_WDATA;
            t_wprev_v = M_AXI_WVALID;
            if (M_AXI_AWVALID && M_AXI_AWREADY) t_addr = M_AXI_AWADDR;
            if (M_AXI_ARVALID && M_AXI_ARREADY) t_addr = M_AXI_ARADDR;
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                t_data = M_AXI_WDATA;
                t_strb = M_AXI_WSTRB;
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    check("spurious_done", 32'(done), 32'h0);
                end else begin
                    e = sbq.pop_front();
                    check("latency",   32'(cyc - e.issue), 32'(e.lat));
                    check("stall_cyc", 32'(t_stall), 32'(e.stall_cyc));
                    check("read_data", read_data, e.rdata);
                    check("resp_err",  32'(resp_err), 32'(e.err));
                    check("req_addr",  t_addr, e.addr);
                    if (e.is_wr) begin
                        check("aw_valid_cyc", 32'(t_aw), 32'(e.a_cyc));
                        check("w_valid_cyc",  32'(t_w),  32'(e.w_cyc));
                        check("wdata",        t_data, e.data);
                        check("wstrb",        32'(t_strb), 32'(e.strb));
                        check("wdata_stable", 32'(t_wchg), 32'h0);
                    end else begin
                        check("ar_valid_cyc", 32'(t_ar), 32'(e.a_cyc));
                    end
                end
                clear_trackers();
            end
        end
    end

    // ---------------- driver ----------------
    // Called aligned just after a rising edge; returns aligned the same way.
    task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                          input int lat, input int stl, input int ac, input int wc,
                          output int done_cyc);
        exp_t e;
        bit   seen;
        mem_write  = wr;
        mem_read   = !wr;
        addr       = a;
        write_data = d;
        byte_en    = be;
        e.is_wr = wr; e.addr = a; e.data = d; e.strb = be; e.rdata = exp_rd;
        e.err = exp_err; e.lat = lat; e.stall_cyc = stl; e.a_cyc = ac; e.w_cyc = wc;
        e.issue = cyc;
        sbq.push_back(e);
        seen = 1'b0;
        done_cyc = -1;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
            end
        end
        if (!seen) check("done_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        mem_read  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, d1;
        clear_trackers();
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        byte_en = 4'h0; addr = 32'h0; write_data = 32'h0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                                 M_AXI_RREADY, done, resp_err, stall}), 32'h0);
        check("reset_awaddr", M_AXI_AWADDR, 32'h0);
        check("reset_wdata", M_AXI_WDATA, 32'h0);
        check("reset_araddr", M_AXI_ARADDR, 32'h0);
        check("reset_rdata", read_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // zero-wait store and load
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 3, 3, 1, 1, d0);
        do_req(1'b0, 32'h24, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 3, 3, 1, 0, d0);

        // W channel ready delayed three cycles, AW immediate
        w_delay = 3;
        do_req(1'b1, 32'h14, 32'h0BAD_F00D, 4'b0011, 32'h1234_5678, 1'b0, 6, 6, 1, 4, d0);
        w_delay = 0;

        // SLVERR on a load, then an OKAY store clears resp_err
        rresp_cfg = 2'b10;
        do_req(1'b0, 32'h24, 32'h0, 4'h0, 32'h1234_5678, 1'b1, 3, 3, 1, 0, d0);
        rresp_cfg = 2'b00;
        do_req(1'b1, 32'h18, 32'h1122_3344, 4'hF, 32'h1234_5678, 1'b0, 3, 3, 1, 1, d0);

        // partial-strobe store landed only in the low half-word
        do_req(1'b0, 32'h14, 32'h0, 4'h0, 32'h0000_F00D, 1'b0, 3, 3, 1, 0, d0);

        // reset while waiting in RD_RESP
        hold_r = 1'b1;
        mem_read = 1'b1; addr = 32'h40;
        repeat (3) @(negedge clk);
        check("rd_resp_wait", 32'({M_AXI_RREADY, M_AXI_ARVALID, stall}), 32'h5);
        rst = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        check("midrd_reset_ctrl", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                                       M_AXI_RREADY, done, stall}), 32'h0);
        hold_r = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("no_done_after_reset", 32'(done), 32'h0);
        end
        @(posedge clk); #1;
        do_req(1'b0, 32'h24, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 3, 3, 1, 0, d0);

        // back-to-back store then load of the same word
        do_req(1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF, 32'h1234_5678, 1'b0, 3, 3, 1, 1, d0);
        do_req(1'b0, 32'h0, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0, 3, 3, 1, 0, d1);
        check("b2b_done_gap", 32'(d1 - d0), 32'h4);

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sbq.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
